// File: rtl/skinny_sbox_layer_seq_d1.sv
// Streams a first-order masked SKINNY-64 state one nibble per cycle through an external
// pipelined HPC2 S-box and reassembles the two output shares without ever combining them.
//
// state | meaning
// IDLE  | waiting for an input state, in_ready high
// FEED  | issuing nibble issue_cnt of each share to the S-box
// DRAIN | all nibbles issued, collecting the remaining S-box outputs
// DONE  | result valid, holding until out_ready
module skinny_sbox_layer_seq_d1 #(
   parameter int NIBBLES  = 16,
   parameter int SBOX_LAT = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_s0,
   input  logic [4*NIBBLES-1:0] in_s1,
   input  logic [3:0]           rnd,
   output logic [3:0]           sbox_x_s0,
   output logic [3:0]           sbox_x_s1,
   output logic [3:0]           sbox_fresh,
   input  logic [3:0]           sbox_y_s0,
   input  logic [3:0]           sbox_y_s1,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_s0,
   output logic [4*NIBBLES-1:0] out_s1,
   output logic                 busy
);

   localparam int CNT_W = $clog2(NIBBLES + 1);
   localparam int IDX_W = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [NIBBLES-1:0][3:0]   in_s0_q, in_s0_d;
   logic [NIBBLES-1:0][3:0]   in_s1_q, in_s1_d;
   logic [NIBBLES-1:0][3:0]   out_s0_q, out_s0_d;
   logic [NIBBLES-1:0][3:0]   out_s1_q, out_s1_d;
   logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]          cap_cnt_q, cap_cnt_d;
   logic [SBOX_LAT-1:0]       vld_pipe_q, vld_pipe_d;
   logic                      out_valid_q, out_valid_d;
   logic                      capture;

   always_comb begin
      state_d     = state_q;
      in_s0_d     = in_s0_q;
      in_s1_d     = in_s1_q;
      out_s0_d    = out_s0_q;
      out_s1_d    = out_s1_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      out_valid_d = out_valid_q;
      capture     = vld_pipe_q[SBOX_LAT-1];
      vld_pipe_d  = {vld_pipe_q[SBOX_LAT-2:0], state_q == FEED};

      // Outputs arrive in issue order, so a single capture counter tracks the lane.
      if (capture) begin
         out_s0_d[cap_cnt_q[IDX_W-1:0]] = sbox_y_s0;
         out_s1_d[cap_cnt_q[IDX_W-1:0]] = sbox_y_s1;
         cap_cnt_d = cap_cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_s0_d     = in_s0;
               in_s1_d     = in_s1;
               issue_cnt_d = '0;
               cap_cnt_d   = '0;
               state_d     = FEED;
            end
         end
         FEED: begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (issue_cnt_q == CNT_W'(NIBBLES - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (capture && cap_cnt_q == CNT_W'(NIBBLES - 1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_s0_q     <= '0;
         in_s1_q     <= '0;
         out_s0_q    <= '0;
         out_s1_q    <= '0;
         issue_cnt_q <= '0;
         cap_cnt_q   <= '0;
         vld_pipe_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_s0_q     <= in_s0_d;
         in_s1_q     <= in_s1_d;
         out_s0_q    <= out_s0_d;
         out_s1_q    <= out_s1_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         vld_pipe_q  <= vld_pipe_d;
         out_valid_q <= out_valid_d;
      end
   end

   // S-box inputs are forced to zero outside FEED so no stale share lingers on them.
   assign sbox_x_s0  = (state_q == FEED) ? in_s0_q[issue_cnt_q[IDX_W-1:0]] : 4'h0;
   assign sbox_x_s1  = (state_q == FEED) ? in_s1_q[issue_cnt_q[IDX_W-1:0]] : 4'h0;
   assign sbox_fresh = rnd;
   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign out_s0     = out_s0_q;
   assign out_s1     = out_s1_q;

endmodule
